pwm_demod: RTL and testbench

//  Receive side of the ICE PWM serial link. Samples PWM_IN and measures the high

---
 rtl/pwm_demod.sv | 220 ++++++++++++++++++++++
 tb/tb_pwm_demod.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// ============================================================================
// pwm_demod : ICE PWM serial link receiver; decodes high-time bits into bytes.
// Optional 3-sample glitch filter enabled by PWM_DEMOD_GLITCH_FILT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module pwm_demod #(
    parameter int BITS_PER_DC = 22,
    parameter int BIT_POS_MAX = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PWM_IN,
    input  logic [BITS_PER_DC-1:0] base_counter,
    input  logic                   rx_en,
    input  logic                   fifo_full,
    output logic                   fifo_WE,
    output logic [BIT_POS_MAX-1:0] fifo_dout,
    output logic                   frame_done,
    output logic                   rx_err,
    output logic                   overflow,
    output logic                   rx_busy
);

    localparam int CW  = BITS_PER_DC + 5;
    localparam int BPW = (BIT_POS_MAX > 1) ? $clog2(BIT_POS_MAX) : 1;
    localparam logic [BPW-1:0] LAST_POS = BPW'(BIT_POS_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HIGH   = 2'd1,
        S_LOW    = 2'd2,
        S_WAITLO = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          hcnt_q, hcnt_d;
    logic [BPW-1:0]         bit_pos_q, bit_pos_d;
    logic [BIT_POS_MAX-1:0] sr_q, sr_d;
    logic                   we_q, we_d;
    logic [BIT_POS_MAX-1:0] dout_q, dout_d;
    logic                   fd_q, fd_d;
    logic                   err_q, err_d;
    logic                   ov_q, ov_d;

    logic s1_q, s2_q, s3_q;
    logic w_level;
    logic w_rise;
    logic w_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= PWM_IN;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

`ifdef PWM_DEMOD_GLITCH_FILT_EN
    // Majority of three consecutive s2 samples, registered; edges use the filtered level.
    logic m1_q, m2_q, f_q, fprev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            m1_q    <= 1'b0;
            m2_q    <= 1'b0;
            f_q     <= 1'b0;
            fprev_q <= 1'b0;
        end else begin
            m1_q    <= s2_q;
            m2_q    <= m1_q;
            f_q     <= (s2_q & m1_q) | (s2_q & m2_q) | (m1_q & m2_q);
            fprev_q <= f_q;
        end
    end

    assign w_level = f_q;
    assign w_rise  = f_q & ~fprev_q;
    assign w_fall  = ~f_q & fprev_q;
`else
    assign w_level = s2_q;
    assign w_rise  = s2_q & ~s3_q;
    assign w_fall  = ~s2_q & s3_q;
`endif

    logic [CW-1:0] w_b;
    logic [CW-1:0] w_thr;
    logic [CW-1:0] w_per;
    logic [CW-1:0] w_eof;
    logic          w_bit;
    logic [BIT_POS_MAX-1:0] w_sr_shift;

    assign w_b        = CW'(base_counter);
    assign w_thr      = (w_b << 2) + w_b;
    assign w_per      = (w_b << 3) + (w_b << 1);
    assign w_eof      = (w_b << 4) + (w_b << 2);
    assign w_bit      = (hcnt_q >= w_thr);
    assign w_sr_shift = {w_bit, sr_q[BIT_POS_MAX-1:1]};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (&x) ? x : x + CW'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        bit_pos_d = bit_pos_q;
        sr_d      = sr_q;
        we_d      = 1'b0;
        dout_d    = dout_q;
        fd_d      = 1'b0;
        err_d     = 1'b0;
        ov_d      = 1'b0;

        if (!rx_en || (base_counter == '0)) begin
            state_d   = S_IDLE;
            bit_pos_d = '0;
            sr_d      = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_rise) begin
                        state_d = S_HIGH;
                        cnt_d   = CW'(1);
                        hcnt_d  = CW'(1);
                    end
                end
                S_HIGH: begin
                    cnt_d  = sat_inc(cnt_q);
                    hcnt_d = sat_inc(hcnt_q);
                    if (w_fall) begin
                        state_d = S_LOW;
                        sr_d    = w_sr_shift;
                        if (bit_pos_q == LAST_POS) begin
                            bit_pos_d = '0;
                            if (!fifo_full) begin
                                we_d   = 1'b1;
                                dout_d = w_sr_shift;
                            end else begin
                                ov_d = 1'b1;
                            end
                        end else begin
                            bit_pos_d = bit_pos_q + BPW'(1);
                        end
                    end else if (hcnt_q >= w_per) begin
                        state_d   = S_WAITLO;
                        err_d     = 1'b1;
                        bit_pos_d = '0;
                        sr_d      = '0;
                    end
                end
                S_LOW: begin
                    cnt_d = sat_inc(cnt_q);
                    // A rise wins over end-of-frame on the same cycle.
                    if (w_rise) begin
                        state_d = S_HIGH;
                        cnt_d   = CW'(1);
                        hcnt_d  = CW'(1);
                    end else if (cnt_q >= w_eof) begin
                        state_d = S_IDLE;
                        fd_d    = 1'b1;
                        if (bit_pos_q != '0) begin
                            err_d     = 1'b1;
                            bit_pos_d = '0;
                            sr_d      = '0;
                        end
                    end
                end
                S_WAITLO: begin
                    if (!w_level) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            bit_pos_q <= '0;
            sr_q      <= '0;
            we_q      <= 1'b0;
            dout_q    <= '0;
            fd_q      <= 1'b0;
            err_q     <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            bit_pos_q <= bit_pos_d;
            sr_q      <= sr_d;
            we_q      <= we_d;
            dout_q    <= dout_d;
            fd_q      <= fd_d;
            err_q     <= err_d;
            ov_q      <= ov_d;
        end
    end

    assign fifo_WE    = we_q;
    assign fifo_dout  = dout_q;
    assign frame_done = fd_q;
    assign rx_err     = err_q;
    assign overflow   = ov_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pwm_demod.sv
// ============================================================================
// tb_pwm_demod : directed, table-driven bench for pwm_demod with b=4.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pwm_demod;

    logic        clk = 1'b0;
    logic        reset;
    logic        pwm;
    logic [21:0] base_counter;
    logic        rx_en;
    logic        fifo_full;
    logic        fifo_WE;
    logic [7:0]  fifo_dout;
    logic        frame_done;
    logic        rx_err;
    logic        overflow;
    logic        rx_busy;

    always #5 clk = ~clk;

    pwm_demod #(.BITS_PER_DC(22), .BIT_POS_MAX(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .PWM_IN       (pwm),
        .base_counter (base_counter),
        .rx_en        (rx_en),
        .fifo_full    (fifo_full),
        .fifo_WE      (fifo_WE),
        .fifo_dout    (fifo_dout),
        .frame_done   (frame_done),
        .rx_err       (rx_err),
        .overflow     (overflow),
        .rx_busy      (rx_busy)
    );

    int checks   = 0;
    int failures = 0;

    int n_we = 0, n_fd = 0, n_err = 0, n_ov = 0, n_err_fd = 0;
    logic [7:0] got[$];

    always @(negedge clk) begin
        if (fifo_WE) begin
            n_we++;
            got.push_back(fifo_dout);
        end
        if (frame_done) n_fd++;
        if (rx_err) n_err++;
        if (overflow) n_ov++;
        if (rx_err && frame_done) n_err_fd++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Transmitter model: 40-clk bit period, 32 high for a one, 8 high for a zero.
    task automatic send_bit(input logic v);
        int h;
        h   = v ? 32 : 8;
        pwm = 1'b1;
        tick(h);
        pwm = 1'b0;
        tick(40 - h);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       full;
        logic       en;
        int         exp_we;
        int         exp_ov;
        int         exp_fd;
    } vec_t;

    vec_t vecs[6];
    int b_we, b_fd, b_err, b_ov, b_efd;

    task automatic snap();
        b_we  = n_we;
        b_fd  = n_fd;
        b_err = n_err;
        b_ov  = n_ov;
        b_efd = n_err_fd;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 1};
        vecs[1] = '{8'h55, 1'b1, 1'b1, 0, 1, 1};
        vecs[2] = '{8'h12, 1'b0, 1'b1, 1, 0, 1};
        vecs[3] = '{8'h77, 1'b0, 1'b0, 0, 0, 0};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 0, 1};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 1, 0, 1};

        reset        = 1'b1;
        pwm          = 1'b0;
        base_counter = 22'd4;
        rx_en        = 1'b1;
        fifo_full    = 1'b0;
        tick(3);
        check("reset_we",   int'(fifo_WE),    0);
        check("reset_dout", int'(fifo_dout),  0);
        check("reset_fd",   int'(frame_done), 0);
        check("reset_err",  int'(rx_err),     0);
        check("reset_ov",   int'(overflow),   0);
        check("reset_busy", int'(rx_busy),    0);
        reset = 1'b0;
        tick(5);

        for (int i = 0; i < 6; i++) begin
            logic [7:0] prev_dout;
            prev_dout = fifo_dout;
            snap();
            fifo_full = vecs[i].full;
            rx_en     = vecs[i].en;
            send_byte(vecs[i].data);
            tick(100);
            fifo_full = 1'b0;
            rx_en     = 1'b1;
            check($sformatf("v%0d_we", i),  n_we - b_we,   vecs[i].exp_we);
            check($sformatf("v%0d_ov", i),  n_ov - b_ov,   vecs[i].exp_ov);
            check($sformatf("v%0d_fd", i),  n_fd - b_fd,   vecs[i].exp_fd);
            check($sformatf("v%0d_err", i), n_err - b_err, 0);
            if (vecs[i].exp_we == 1 && got.size() > 0)
                check($sformatf("v%0d_byte", i), int'(got[got.size()-1]), int'(vecs[i].data));
            else
                check($sformatf("v%0d_dout_held", i), int'(fifo_dout), int'(prev_dout));
            tick(5);
        end

        // Back-to-back frame of three bytes.
        snap();
        send_byte(8'h3C);
        send_byte(8'hFF);
        send_byte(8'h00);
        tick(100);
        check("b2b_we", n_we - b_we, 3);
        check("b2b_fd", n_fd - b_fd, 1);
        if (got.size() >= 3) begin
            check("b2b_b0", int'(got[got.size()-3]), 'h3C);
            check("b2b_b1", int'(got[got.size()-2]), 'hFF);
            check("b2b_b2", int'(got[got.size()-1]), 'h00);
        end else begin
            check("b2b_count", got.size(), 3);
        end

        // Partial byte: three bits then a long low.
        snap();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(100);
        check("part_we",    n_we - b_we,      0);
        check("part_err",   n_err - b_err,    1);
        check("part_fd",    n_fd - b_fd,      1);
        check("part_errfd", n_err_fd - b_efd, 1);
        snap();
        send_byte(8'h81);
        tick(100);
        check("after_part_we", n_we - b_we, 1);
        check("after_part_byte", int'(got[got.size()-1]), 'h81);

        // Stuck-high line.
        snap();
        pwm = 1'b1;
        tick(60);
        check("stuck_err",  n_err - b_err, 1);
        check("stuck_busy", int'(rx_busy), 1);
        pwm = 1'b0;
        tick(8);
        check("stuck_idle", int'(rx_busy), 0);
        check("stuck_fd",   n_fd - b_fd,   0);
        tick(20);

        // Reset in the middle of 0xF0.
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        reset = 1'b1;
        tick(1);
        check("mid_rst_we",   int'(fifo_WE),    0);
        check("mid_rst_dout", int'(fifo_dout),  0);
        check("mid_rst_fd",   int'(frame_done), 0);
        check("mid_rst_err",  int'(rx_err),     0);
        check("mid_rst_ov",   int'(overflow),   0);
        check("mid_rst_busy", int'(rx_busy),    0);
        reset = 1'b0;
        tick(5);
        snap();
        send_byte(8'h0F);
        tick(100);
        check("post_rst_we",   n_we - b_we, 1);
        check("post_rst_byte", int'(fifo_dout), 'h0F);
        check("post_rst_err",  n_err - b_err, 0);

`ifdef PWM_DEMOD_GLITCH_FILT_EN
        // One-clock spikes inside each low phase must be ignored.
        snap();
        for (int i = 0; i < 8; i++) begin
            pwm = 1'b1;
            tick(8);
            pwm = 1'b0;
            tick(12);
            pwm = 1'b1;
            tick(1);
            pwm = 1'b0;
            tick(19);
        end
        tick(100);
        check("spike_we",   n_we - b_we, 1);
        check("spike_byte", int'(fifo_dout), 'h00);
        check("spike_err",  n_err - b_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
